pipelined_floating_point_addsub: RTL and testbench
==================================================

# pipelined_floating_point_addsub

Parametrised, pipelined successor to the combinational floating-point adder/subtractor. It accepts one operand pair per cycle under a valid/ready handshake and returns an IEEE-754-style add or subtract result after a fixed four-stage latency. Results carry rounding, special-value handling and status flags. It sits between the operand issue logic and the result writeback of the floating-point unit.

## Interface
- DATA_WIDTH, 32, total word width; must equal 1 + EXPO_WIDTH + MENT_WIDTH
- MENT_WIDTH, 23, stored mantissa bits (hidden bit excluded)
- EXPO_WIDTH, 8, exponent bits; bias = 2^(EXPO_WIDTH-1) - 1
- TAG_WIDTH, 4, user tag carried alongside each operation

- clk_in  input  1  clock; all state updates on the rising edge
- rst_in  input  1  reset; synchronous and active-high
- valid_in  input  1  operand pair is present
- ready_out  output  1  block accepts an operand pair this cycle
- floating1_in  input  DATA_WIDTH  operand A
- floating2_in  input  DATA_WIDTH  operand B
- opcode_in  input  1  0 = A+B, 1 = A-B
- tag_in  input  TAG_WIDTH  user tag
- valid_out  output  1  result is present
- ready_in  input  1  downstream accepts the result
- floating_addition_out  output  DATA_WIDTH  result
- tag_out  output  TAG_WIDTH  tag of the result
- flags_out  output  4  {invalid, overflow, underflow, inexact}

## Operation
- Stage 1: unpack the operands and invert the sign of B when opcode_in=1. Classify each operand as zero, normal, inf or NaN. A subnormal input (exponent 0, mantissa ≠ 0) is flushed to a signed zero. Swap the operands so the larger magnitude is the first operand.
- Stage 2: right-shift the smaller significand by the exponent difference. Keep guard, round and sticky bits. A shift ≥ MENT_WIDTH+3 leaves only the sticky bit.
- Stage 3: add the significands when the signs match, otherwise subtract them (larger minus smaller). The result sign is the sign of the larger operand.
- Stage 4: normalise with a 1-bit right shift or a leading-zero-count left shift, adjusting the exponent. Round (see Configuration), renormalise on mantissa carry-out, then pack the result.
- Special cases, with priority from top to bottom:
  - Either operand NaN, or inf − inf: result 0_1…1_10…0 (canonical quiet NaN), invalid=1.
  - A single inf operand: result is that inf with its effective sign.
  - Exact-zero result: +0. The exception is −0 + −0, which gives −0.
- Overflow (exponent ≥ all-ones after rounding): result ±inf, overflow=1, inexact=1.
- Underflow (exponent ≤ 0 after normalisation): result signed zero, underflow=1, inexact=1.
- inexact=1 whenever any of guard, round or sticky is nonzero after normalisation.
- tag_in travels with its operation unchanged.

## Timing
- Latency: 4 cycles from the accepting edge (valid_in & ready_out) to valid_out=1 with that result.
- Throughput: 1 operation per cycle while ready_in=1.
- Global advance: advance = ~valid_out | ready_in, and ready_out = advance. ready_out is combinational from ready_in and valid_out; there is no other combinational path from input to output.
- When advance=0, all stage registers hold. valid_out and all result outputs stay stable until accepted (valid_out & ready_in).
- Bubbles (valid_in=0 while ready_out=1) propagate as valid=0 stages. Non-valid stage data is don't-care but is still registered.
- Simultaneous output accept and new input: both occur in the same cycle, with no bubble inserted.
- Reset: on a clock edge with rst_in=1, all stage valid bits clear. valid_out, floating_addition_out, tag_out and flags_out are all 0 after that edge, and ready_out=1 in the first cycle after reset. In-flight operations are discarded.

## Configuration
- FP_ADDSUB_ROUND_NEAREST_EN defined: round to nearest, ties to even, using guard/round/sticky.
- FP_ADDSUB_ROUND_NEAREST_EN undefined: truncate toward zero. Overflow then saturates to the largest finite value (exponent all-ones minus 1, mantissa all-ones) instead of inf. inexact is still reported.

## Test plan
- Directed add/sub, tag 0x1, single issue:
  - 0x43876000 + 0x40180000, opcode 0 → 0x43889000, flags 0000, valid_out exactly 4 cycles after acceptance.
  - The same pair with opcode 1 → 0x43863000.
  - The operands swapped with opcode 1 → 0xC3863000.
- Special values:
  - 0x3F800000 − 0x3F800000 → 0x00000000.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1.
  - 0x7FC00000 + 0x3F800000 → 0x7FC00000, invalid=1.
  - Subnormal 0x00000001 + 0x00000000 → 0x00000000.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with overflow and inexact set when the macro is defined; 0x7F7FFFFF when it is undefined.
- Rounding, macro defined:
  - 0x3F800000 + 0x33800000 → 0x3F800000 (tie to even), inexact=1.
  - 0x3F800000 + 0x33C00000 → 0x3F800001.
  - Macro undefined: both cases → 0x3F800000.
- Back-pressure: stream 8 back-to-back operations with tags 0–7 and hold ready_in=0 for 3 cycles mid-stream. Required: ready_out drops while the output is stalled, outputs stay stable, and all 8 results arrive in tag order with no loss or duplication.
- Reset mid-stream: assert rst_in for 1 cycle with 3 operations in flight. Required: valid_out=0 and all outputs 0 on the next cycle, and no stale result appears afterwards.

Source files
------------

// File: rtl/pipelined_floating_point_addsub_if.sv
// Operand/result handshake bundle for pipelined_floating_point_addsub.
// slave is the adder side, master is the issue/writeback side.
interface pipelined_floating_point_addsub_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic                  valid_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] floating1_in;
  logic [DATA_WIDTH-1:0] floating2_in;
  logic                  opcode_in;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic                  valid_out;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] floating_addition_out;
  logic [TAG_WIDTH-1:0]  tag_out;
  logic [3:0]            flags_out;

  modport slave (
    input  valid_in, floating1_in, floating2_in, opcode_in, tag_in, ready_in,
    output ready_out, valid_out, floating_addition_out, tag_out, flags_out
  );

  modport master (
    output valid_in, floating1_in, floating2_in, opcode_in, tag_in, ready_in,
    input  ready_out, valid_out, floating_addition_out, tag_out, flags_out
  );
endinterface

// File: rtl/pipelined_floating_point_addsub.sv
// Four-stage IEEE-754-style adder/subtractor with valid/ready flow control.
// FP_ADDSUB_ROUND_NEAREST_EN selects round-nearest-even; otherwise truncate with saturation.
module pipelined_floating_point_addsub #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8,
  parameter int TAG_WIDTH  = 4
) (
  input logic clk_in,
  input logic rst_in,
  pipelined_floating_point_addsub_if.slave bus
);
  localparam int M   = MENT_WIDTH;
  localparam int E   = EXPO_WIDTH;
  localparam int SW  = M + 1;
  localparam int AW  = M + 4;
  localparam int LZW = $clog2(AW + 1);
  localparam int XW  = E + 2;
  localparam logic [E-1:0] EXP_ONES       = '1;
  localparam logic [E-1:0] EXP_MAX_FINITE = EXP_ONES - E'(1);

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic                 nan;
    logic                 inf;
    logic                 neg_zero;
    logic                 sign;
  } ctl_t;

  logic advance;
  assign advance       = ~bus.valid_out | bus.ready_in;
  assign bus.ready_out = advance;

  // ---------------- stage 1: unpack, classify, swap ----------------
  logic          a_sign, b_sign;
  logic [E-1:0]  a_exp, b_exp;
  logic [M-1:0]  a_man, b_man;
  logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [SW-1:0] a_sig, b_sig;
  logic          a_larger;
  ctl_t          in_ctl;

  always_comb begin
    a_sign   = bus.floating1_in[DATA_WIDTH-1];
    a_exp    = bus.floating1_in[M +: E];
    a_man    = bus.floating1_in[M-1:0];
    b_sign   = bus.floating2_in[DATA_WIDTH-1] ^ bus.opcode_in;
    b_exp    = bus.floating2_in[M +: E];
    b_man    = bus.floating2_in[M-1:0];
    a_zero   = (a_exp == '0);
    b_zero   = (b_exp == '0);
    a_inf    = (a_exp == EXP_ONES) && (a_man == '0);
    b_inf    = (b_exp == EXP_ONES) && (b_man == '0);
    a_nan    = (a_exp == EXP_ONES) && (a_man != '0);
    b_nan    = (b_exp == EXP_ONES) && (b_man != '0);
    // subnormals collapse to a signed zero with an all-zero significand
    a_sig    = a_zero ? '0 : {1'b1, a_man};
    b_sig    = b_zero ? '0 : {1'b1, b_man};
    a_larger = ({a_exp, a_sig} >= {b_exp, b_sig});

    in_ctl.valid    = bus.valid_in;
    in_ctl.tag      = bus.tag_in;
    in_ctl.nan      = a_nan | b_nan | (a_inf & b_inf & (a_sign ^ b_sign));
    in_ctl.inf      = a_inf | b_inf;
    in_ctl.neg_zero = a_zero & b_zero & a_sign & b_sign;
    in_ctl.sign     = a_larger ? a_sign : b_sign;
  end

  ctl_t          s1_ctl;
  logic          s1_sub;
  logic [E-1:0]  s1_exp_l, s1_exp_s;
  logic [SW-1:0] s1_sig_l, s1_sig_s;

  // ---------------- stage 2: alignment ----------------
  logic [E-1:0]    exp_diff;
  logic [2*AW-1:0] shift_full;
  logic [AW-1:0]   aligned;

  always_comb begin
    exp_diff   = s1_exp_l - s1_exp_s;
    shift_full = '0;
    if (32'(exp_diff) >= 32'(AW - 1)) begin
      aligned = {{(AW-1){1'b0}}, |s1_sig_s};
    end else begin
      // lower half collects every bit shifted past the sticky position
      shift_full = {s1_sig_s, 3'b000, {AW{1'b0}}} >> exp_diff;
      aligned    = {shift_full[2*AW-1:AW+1], shift_full[AW] | (|shift_full[AW-1:0])};
    end
  end

  ctl_t          s2_ctl;
  logic          s2_sub;
  logic [E-1:0]  s2_exp;
  logic [SW-1:0] s2_sig_l;
  logic [AW-1:0] s2_aligned;

  // ---------------- stage 3: add / subtract ----------------
  logic [AW:0] big_ext, sum;

  always_comb begin
    big_ext = {1'b0, s2_sig_l, 3'b000};
    sum     = s2_sub ? (big_ext - {1'b0, s2_aligned}) : (big_ext + {1'b0, s2_aligned});
  end

  ctl_t         s3_ctl;
  logic [E-1:0] s3_exp;
  logic [AW:0]  s3_sum;

  // ---------------- stage 4: normalise, round, pack ----------------
  logic [LZW-1:0]        lz;
  logic [AW-1:0]         norm;
  logic [XW-1:0]         exp_n, exp_r;
  logic [M-1:0]          man;
  logic [M:0]            man_r;
  logic                  round_up, inexact;
  logic [DATA_WIDTH-1:0] res_word;
  logic [3:0]            res_flags;

  always_comb begin
    lz = LZW'(AW);
    for (int unsigned i = 0; i < AW; i++) begin
      if (s3_sum[i]) lz = LZW'(AW - 1 - i);
    end

    // exponent math is two's complement in XW bits; the MSB flags a negative value
    if (s3_sum[AW]) begin
      norm  = {s3_sum[AW:2], s3_sum[1] | s3_sum[0]};
      exp_n = {2'b00, s3_exp} + XW'(1);
    end else begin
      norm  = s3_sum[AW-1:0] << lz;
      exp_n = {2'b00, s3_exp} - {{(XW-LZW){1'b0}}, lz};
    end

    man     = norm[AW-2:3];
    inexact = |norm[2:0];
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
    round_up = norm[2] & (norm[1] | norm[0] | man[0]);
`else
    round_up = 1'b0;
`endif
    // a carry out of the mantissa leaves man_r[M-1:0] all zero, so only the exponent bumps
    man_r = {1'b0, man} + {{M{1'b0}}, round_up};
    exp_r = exp_n + {{(XW-1){1'b0}}, man_r[M]};

    res_word  = '0;
    res_flags = '0;
    if (s3_ctl.nan) begin
      res_word  = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
      res_flags = 4'b1000;
    end else if (s3_ctl.inf) begin
      res_word = {s3_ctl.sign, EXP_ONES, {M{1'b0}}};
    end else if (s3_sum == '0) begin
      res_word = {s3_ctl.neg_zero, {(DATA_WIDTH-1){1'b0}}};
    end else if (exp_n[XW-1] || (exp_n == '0)) begin
      res_word  = {s3_ctl.sign, {(DATA_WIDTH-1){1'b0}}};
      res_flags = 4'b0011;
    end else if (exp_r >= {2'b00, EXP_ONES}) begin
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
      res_word = {s3_ctl.sign, EXP_ONES, {M{1'b0}}};
`else
      res_word = {s3_ctl.sign, EXP_MAX_FINITE, {M{1'b1}}};
`endif
      res_flags = 4'b0101;
    end else begin
      res_word  = {s3_ctl.sign, exp_r[E-1:0], man_r[M-1:0]};
      res_flags = {3'b000, inexact};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_ctl.valid              <= 1'b0;
      s2_ctl.valid              <= 1'b0;
      s3_ctl.valid              <= 1'b0;
      bus.valid_out             <= 1'b0;
      bus.floating_addition_out <= '0;
      bus.tag_out               <= '0;
      bus.flags_out             <= '0;
    end else if (advance) begin
      s1_ctl   <= in_ctl;
      s1_sub   <= a_sign ^ b_sign;
      s1_exp_l <= a_larger ? a_exp : b_exp;
      s1_exp_s <= a_larger ? b_exp : a_exp;
      s1_sig_l <= a_larger ? a_sig : b_sig;
      s1_sig_s <= a_larger ? b_sig : a_sig;

      s2_ctl     <= s1_ctl;
      s2_sub     <= s1_sub;
      s2_exp     <= s1_exp_l;
      s2_sig_l   <= s1_sig_l;
      s2_aligned <= aligned;

      s3_ctl <= s2_ctl;
      s3_exp <= s2_exp;
      s3_sum <= sum;

      bus.valid_out             <= s3_ctl.valid;
      bus.floating_addition_out <= res_word;
      bus.tag_out               <= s3_ctl.tag;
      bus.flags_out             <= res_flags;
    end
  end
endmodule

// File: tb/tb_pipelined_floating_point_addsub.sv
// Scoreboard bench for pipelined_floating_point_addsub: directed vectors, stall and reset.
// Expected values follow FP_ADDSUB_ROUND_NEAREST_EN the same way as the design.
module tb_pipelined_floating_point_addsub;
  localparam int DW = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_floating_point_addsub_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) fp_bus ();

  pipelined_floating_point_addsub #(
    .DATA_WIDTH(DW), .MENT_WIDTH(23), .EXPO_WIDTH(8), .TAG_WIDTH(TW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (fp_bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic [3:0]  tag;
    int unsigned cyc;
    bit          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic add_vec(input logic [31:0] a, b, input logic op, input logic [31:0] r, input logic [3:0] f);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.r = r; v.f = f;
    vecs.push_back(v);
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic issue(input vec_t v, input logic [3:0] tag, input bit lat);
    int unsigned waited = 0;
    exp_t e;
    fp_bus.valid_in     = 1'b1;
    fp_bus.floating1_in = v.a;
    fp_bus.floating2_in = v.b;
    fp_bus.opcode_in    = v.op;
    fp_bus.tag_in       = tag;
    @(negedge clk);
    while (!fp_bus.ready_out && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!fp_bus.ready_out) begin
      check_value("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.res = v.r; e.flags = v.f; e.tag = tag; e.cyc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    fp_bus.valid_in = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_value(name, sb.size(), 32'd0);
  endtask

  // Output monitor: scoreboard compare on transfer, stability while stalled.
  logic        hold_prev = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_tag, prev_flags;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check_value("stall_valid", 32'(fp_bus.valid_out), 32'd1);
        check_value("stall_data", fp_bus.floating_addition_out, prev_res);
        check_value("stall_tag", 32'(fp_bus.tag_out), 32'(prev_tag));
        check_value("stall_flags", 32'(fp_bus.flags_out), 32'(prev_flags));
      end
      if (fp_bus.valid_out && !fp_bus.ready_in)
        check_value("stall_ready_out", 32'(fp_bus.ready_out), 32'd0);
      if (fp_bus.valid_out && fp_bus.ready_in) begin
        if (sb.size() == 0) begin
          check_value("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_value("result", fp_bus.floating_addition_out, e.res);
          check_value("flags", 32'(fp_bus.flags_out), 32'(e.flags));
          check_value("tag", 32'(fp_bus.tag_out), 32'(e.tag));
          if (e.lat) check_value("latency", cyc - e.cyc, 32'd4);
        end
      end
      hold_prev  = fp_bus.valid_out && !fp_bus.ready_in;
      prev_res   = fp_bus.floating_addition_out;
      prev_tag   = fp_bus.tag_out;
      prev_flags = fp_bus.flags_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    add_vec(32'h43876000, 32'h40180000, 1'b0, 32'h43889000, 4'b0000);
    add_vec(32'h43876000, 32'h40180000, 1'b1, 32'h43863000, 4'b0000);
    add_vec(32'h40180000, 32'h43876000, 1'b1, 32'hC3863000, 4'b0000);
    add_vec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    add_vec(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    add_vec(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    add_vec(32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    add_vec(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001);
`else
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 4'b0101);
    add_vec(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 4'b0001);
`endif
    add_vec(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    add_vec(32'h3F800000, 32'h32800000, 1'b0, 32'h3F800000, 4'b0001);
    add_vec(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    add_vec(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    add_vec(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000);
    add_vec(32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000);
    add_vec(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000);
    add_vec(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);

    rst                 = 1'b1;
    fp_bus.valid_in     = 1'b0;
    fp_bus.floating1_in = '0;
    fp_bus.floating2_in = '0;
    fp_bus.opcode_in    = 1'b0;
    fp_bus.tag_in       = '0;
    fp_bus.ready_in     = 1'b1;

    @(negedge clk);
    check_value("reset_valid_out", 32'(fp_bus.valid_out), 32'd0);
    check_value("reset_data", fp_bus.floating_addition_out, 32'd0);
    check_value("reset_tag", 32'(fp_bus.tag_out), 32'd0);
    check_value("reset_flags", 32'(fp_bus.flags_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_value("reset_ready_out", 32'(fp_bus.ready_out), 32'd1);
    @(posedge clk); #1;

    // Single issue: latency checked on every result.
    foreach (vecs[i]) begin
      issue(vecs[i], 4'h1, 1'b1);
      drain("single_drain");
      @(posedge clk); #1;
    end

    // Back-to-back stream with a 3-cycle output stall in the middle.
    fork
      begin
        for (int t = 0; t < 8; t++) issue(vecs[t], 4'(t), 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 fp_bus.ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 fp_bus.ready_in = 1'b1;
      end
    join
    drain("stream_drain");
    @(posedge clk); #1;

    // Reset with three operations in flight.
    for (int t = 0; t < 3; t++) issue(vecs[t], 4'(9 + t), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_value("midrst_valid_out", 32'(fp_bus.valid_out), 32'd0);
    check_value("midrst_data", fp_bus.floating_addition_out, 32'd0);
    check_value("midrst_tag", 32'(fp_bus.tag_out), 32'd0);
    check_value("midrst_flags", 32'(fp_bus.flags_out), 32'd0);
    check_value("midrst_ready_out", 32'(fp_bus.ready_out), 32'd1);
    repeat (8) begin
      @(negedge clk);
      check_value("no_stale", 32'(fp_bus.valid_out), 32'd0);
    end
    @(posedge clk); #1;

    issue(vecs[12], 4'h5, 1'b1);
    drain("post_reset_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
